// File: rtl/accel_dispatch.sv
// accel_dispatch: queues CPU kicks for the hash/encrypt/decrypt engines in an
// in-order FIFO, starts each job when its engine is free, and returns done pulses.
// Optional per-engine watchdog enabled with `define ACCEL_TIMEOUT_EN.
module accel_dispatch #(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned IDX_W   = 11,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     H_int,
  input  logic                     E_int,
  input  logic                     D_int,
  input  logic [IDX_W-1:0]         index,
  input  logic                     flush,
  input  logic                     H_fin,
  input  logic                     E_fin,
  input  logic                     D_fin,
  output logic                     H_start,
  output logic                     E_start,
  output logic                     D_start,
  output logic [IDX_W-1:0]         eng_index,
  output logic                     H_done,
  output logic                     E_done,
  output logic                     D_done,
  output logic [2:0]               busy,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     ovf_err,
  output logic                     spur_err,
  output logic [2:0]               timeout_err
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  // Command FIFO storage: engine type (0=H, 1=E, 2=D) and job index
  logic [1:0]       typ_q [DEPTH];
  logic [IDX_W-1:0] idx_q [DEPTH];

  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [2:0]       busy_q, busy_d, start_q, start_d, done_q, done_d;
  logic [IDX_W-1:0] eng_index_q, eng_index_d;
  logic             ovf_q, ovf_d, spur_q, spur_d;

  logic [2:0]       kick_c, fin_c, head_oh_c, tmo_fire_c;
  logic [1:0]       kick_typ_c, head_typ_c;
  logic             any_kick_c, multi_kick_c, full_c, dispatch_c, push_c;

  // Next-state logic for FIFO, dispatch, completion and sticky flags
  always_comb begin
    kick_c       = {D_int, E_int, H_int};
    fin_c        = {D_fin, E_fin, H_fin};
    any_kick_c   = |kick_c;
    multi_kick_c = (H_int & E_int) | (H_int & D_int) | (E_int & D_int);
    kick_typ_c   = H_int ? 2'd0 : (E_int ? 2'd1 : 2'd2);
    full_c       = (count_q == CNT_W'(DEPTH));
    head_typ_c   = typ_q[rd_ptr_q];
    head_oh_c    = 3'b001 << head_typ_c;

    // Dispatch sees the pre-edge busy value, so a fin and a start never coincide
    dispatch_c   = (count_q != '0) && !flush && ((head_oh_c & busy_q) == 3'b000);
    push_c       = any_kick_c && !flush && (!full_c || dispatch_c);

    rd_ptr_d     = rd_ptr_q;
    wr_ptr_d     = wr_ptr_q;
    count_d      = count_q;
    start_d      = 3'b000;
    eng_index_d  = '0;
    ovf_d        = ovf_q;
    spur_d       = spur_q;

    if (dispatch_c) begin
      rd_ptr_d    = rd_ptr_q + PTR_W'(1);
      start_d     = head_oh_c;
      eng_index_d = idx_q[rd_ptr_q];
    end
    if (push_c) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    count_d = count_q + CNT_W'(push_c) - CNT_W'(dispatch_c);

    // Flush empties the queue; kicks in the same cycle vanish without an error
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end

    if (any_kick_c && !flush && (multi_kick_c || (full_c && !dispatch_c))) begin
      ovf_d = 1'b1;
    end
    if ((fin_c & ~busy_q) != 3'b000) begin
      spur_d = 1'b1;
    end

    done_d = (fin_c & busy_q) | tmo_fire_c;
    busy_d = (busy_q & ~done_d) | start_d;
  end

  // Control and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      busy_q      <= 3'b000;
      start_q     <= 3'b000;
      done_q      <= 3'b000;
      eng_index_q <= '0;
      ovf_q       <= 1'b0;
      spur_q      <= 1'b0;
    end else begin
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      busy_q      <= busy_d;
      start_q     <= start_d;
      done_q      <= done_d;
      eng_index_q <= eng_index_d;
      ovf_q       <= ovf_d;
      spur_q      <= spur_d;
    end
  end

  // FIFO payload write; contents are don't-care until pushed
  always_ff @(posedge clk) begin
    if (push_c) begin
      typ_q[wr_ptr_q] <= kick_typ_c;
      idx_q[wr_ptr_q] <= index;
    end
  end

`ifdef ACCEL_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);

  logic [TMO_W-1:0] tmo_cnt_q [3];
  logic [2:0]       tmo_err_q;

  // Watchdog fires on the last busy cycle unless the engine reports fin
  always_comb begin
    tmo_fire_c = 3'b000;
    for (int e = 0; e < 3; e++) begin
      tmo_fire_c[e] = busy_q[e] && !fin_c[e] && (tmo_cnt_q[e] == TMO_W'(TIMEOUT - 1));
    end
  end

  // Per-engine cycle counters, restarted on dispatch; sticky timeout flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int e = 0; e < 3; e++) tmo_cnt_q[e] <= '0;
      tmo_err_q <= 3'b000;
    end else begin
      for (int e = 0; e < 3; e++) begin
        if (start_d[e]) tmo_cnt_q[e] <= '0;
        else if (busy_q[e]) tmo_cnt_q[e] <= tmo_cnt_q[e] + TMO_W'(1);
      end
      tmo_err_q <= tmo_err_q | tmo_fire_c;
    end
  end

  assign timeout_err = tmo_err_q;
`else
  // TIMEOUT has no function without the watchdog
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT == 0);
  assign tmo_fire_c     = 3'b000;
  assign timeout_err    = 3'b000;
`endif

  assign H_start    = start_q[0];
  assign E_start    = start_q[1];
  assign D_start    = start_q[2];
  assign H_done     = done_q[0];
  assign E_done     = done_q[1];
  assign D_done     = done_q[2];
  assign eng_index  = eng_index_q;
  assign busy       = busy_q;
  assign fifo_count = count_q;
  assign ovf_err    = ovf_q;
  assign spur_err   = spur_q;

endmodule

// File: tb/tb_accel_dispatch.sv
// Self-checking bench for accel_dispatch: queue-based reference model,
// directed scenarios with literal expectations, then randomized traffic.
module tb_accel_dispatch;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned IDX_W = 11;
`ifdef ACCEL_TIMEOUT_EN
  localparam int unsigned TB_TMO = 16;
`else
  localparam int unsigned TB_TMO = 1024;
`endif

  logic clk, rst;
  logic H_int, E_int, D_int, flush, H_fin, E_fin, D_fin;
  logic [IDX_W-1:0] index;
  logic H_start, E_start, D_start, H_done, E_done, D_done;
  logic [IDX_W-1:0] eng_index;
  logic [2:0] busy, timeout_err;
  logic [$clog2(DEPTH):0] fifo_count;
  logic ovf_err, spur_err;

  accel_dispatch #(.DEPTH(DEPTH), .IDX_W(IDX_W), .TIMEOUT(TB_TMO)) dut (
    .clk(clk), .rst(rst),
    .H_int(H_int), .E_int(E_int), .D_int(D_int), .index(index), .flush(flush),
    .H_fin(H_fin), .E_fin(E_fin), .D_fin(D_fin),
    .H_start(H_start), .E_start(E_start), .D_start(D_start), .eng_index(eng_index),
    .H_done(H_done), .E_done(E_done), .D_done(D_done),
    .busy(busy), .fifo_count(fifo_count),
    .ovf_err(ovf_err), .spur_err(spur_err), .timeout_err(timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: expected outputs for the current cycle plus the job queue
  logic [2:0]       m_busy, m_start, m_done, m_tmo;
  logic [IDX_W-1:0] m_idx;
  logic             m_ovf, m_spur;
  logic [IDX_W+1:0] m_q [$];
  int               cyc;
  int               st_cyc [3];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_busy = 3'b000; m_start = 3'b000; m_done = 3'b000; m_tmo = 3'b000;
    m_idx = '0; m_ovf = 1'b0; m_spur = 1'b0;
    m_q.delete();
    cyc = 0;
    for (int e = 0; e < 3; e++) st_cyc[e] = 0;
  endtask

  // Compare every DUT output with the model for the current cycle
  task automatic check_outputs();
    chk("H_start", 32'(H_start), 32'(m_start[0]));
    chk("E_start", 32'(E_start), 32'(m_start[1]));
    chk("D_start", 32'(D_start), 32'(m_start[2]));
    if (m_start != 3'b000) chk("eng_index", 32'(eng_index), 32'(m_idx));
    chk("H_done", 32'(H_done), 32'(m_done[0]));
    chk("E_done", 32'(E_done), 32'(m_done[1]));
    chk("D_done", 32'(D_done), 32'(m_done[2]));
    chk("busy", 32'(busy), 32'(m_busy));
    chk("fifo_count", 32'(fifo_count), 32'(m_q.size()));
    chk("ovf_err", 32'(ovf_err), 32'(m_ovf));
    chk("spur_err", 32'(spur_err), 32'(m_spur));
    chk("timeout_err", 32'(timeout_err), 32'(m_tmo));
  endtask

  // Advance the model by one clock edge given this cycle's inputs
  task automatic model_step(input logic [2:0] kick, input logic [IDX_W-1:0] ix,
                            input logic fl, input logic [2:0] fin);
    logic [2:0]       nb, ns, nd;
    logic [IDX_W-1:0] nidx;
    logic [IDX_W+1:0] ent;
    int               eh, es;
    nb = m_busy; ns = 3'b000; nd = 3'b000; nidx = '0;
    for (int e = 0; e < 3; e++) begin
      if (fin[e]) begin
        if (m_busy[e]) begin nb[e] = 1'b0; nd[e] = 1'b1; end
        else m_spur = 1'b1;
      end
`ifdef ACCEL_TIMEOUT_EN
      else if (m_busy[e] && (cyc + 1 == st_cyc[e] + int'(TB_TMO))) begin
        nb[e] = 1'b0; nd[e] = 1'b1; m_tmo[e] = 1'b1;
      end
`endif
    end
    if (!fl && m_q.size() > 0) begin
      ent = m_q[0];
      eh  = int'(ent[IDX_W+1:IDX_W]);
      if (!m_busy[eh]) begin
        ns[eh] = 1'b1; nb[eh] = 1'b1; nidx = ent[IDX_W-1:0];
        void'(m_q.pop_front());
        st_cyc[eh] = cyc + 1;
      end
    end
    if (fl) begin
      m_q.delete();
    end else if (kick != 3'b000) begin
      if ($countones(kick) > 1) m_ovf = 1'b1;
      es = kick[0] ? 0 : (kick[1] ? 1 : 2);
      if (m_q.size() < int'(DEPTH)) m_q.push_back({2'(es), ix});
      else m_ovf = 1'b1;
    end
    m_busy = nb; m_start = ns; m_done = nd; m_idx = nidx;
    cyc++;
  endtask

  // One cycle: check outputs at the falling edge, then drive the next inputs
  task automatic step(input logic [2:0] kick, input logic [IDX_W-1:0] ix,
                      input logic fl, input logic [2:0] fin);
    @(negedge clk);
    check_outputs();
    H_int = kick[0]; E_int = kick[1]; D_int = kick[2];
    index = ix; flush = fl;
    H_fin = fin[0]; E_fin = fin[1]; D_fin = fin[2];
    model_step(kick, ix, fl, fin);
  endtask

  task automatic idle(input int n);
    repeat (n) step(3'b000, '0, 1'b0, 3'b000);
  endtask

  task automatic reset_dut(input bit lit);
    rst = 1'b1;
    H_int = 0; E_int = 0; D_int = 0; index = '0; flush = 0;
    H_fin = 0; E_fin = 0; D_fin = 0;
    #1;
    if (lit) begin
      chk("rst_starts", 32'({H_start, E_start, D_start}), 32'd0);
      chk("rst_dones", 32'({H_done, E_done, D_done}), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_count", 32'(fifo_count), 32'd0);
      chk("rst_flags", 32'({ovf_err, spur_err, timeout_err}), 32'd0);
      chk("rst_eng_index", 32'(eng_index), 32'd0);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    logic [2:0] k, f;
    int finp;
    model_reset();
    reset_dut(1'b1);

    // Single hash job: start two cycles after the kick, done one after fin
    step(3'b001, 11'h123, 0, 3'b000);            // cycle 0
    idle(2);                                     // cycles 1,2
    chk("lat_H_start", 32'(H_start), 32'd1);
    chk("lat_eng_index", 32'(eng_index), 32'h123);
    chk("lat_busy", 32'(busy), 32'b001);
    idle(7);                                     // cycles 3..9
    step(3'b000, '0, 0, 3'b001);                 // cycle 10: H_fin
    step(3'b000, '0, 0, 3'b000);                 // cycle 11
    chk("fin_H_done", 32'(H_done), 32'd1);
    chk("fin_busy", 32'(busy), 32'd0);
    idle(1);
    chk("fin_H_done_once", 32'(H_done), 32'd0);

    // Head-of-line blocking: E waits behind a queued H job
    step(3'b001, 11'h100, 0, 3'b000);
    idle(2);
    step(3'b001, 11'h001, 0, 3'b000);
    step(3'b010, 11'h002, 0, 3'b000);
    idle(3);
    chk("hol_count", 32'(fifo_count), 32'd2);
    chk("hol_busy", 32'(busy), 32'b001);
    step(3'b000, '0, 0, 3'b001);
    idle(2);
    chk("hol_H_start", 32'(H_start), 32'd1);
    chk("hol_H_index", 32'(eng_index), 32'h001);
    idle(1);
    chk("hol_E_start", 32'(E_start), 32'd1);
    chk("hol_E_index", 32'(eng_index), 32'h002);
    chk("hol_busy2", 32'(busy), 32'b011);
    step(3'b000, '0, 0, 3'b011);
    idle(2);

    // Simultaneous H and E kick: only H queued, overflow flagged
    reset_dut(1'b0);
    step(3'b011, 11'h055, 0, 3'b000);
    idle(1);
    chk("multi_ovf", 32'(ovf_err), 32'd1);
    chk("multi_count", 32'(fifo_count), 32'd1);
    idle(3);
    chk("multi_busy", 32'(busy), 32'b001);

    // Full FIFO with all engines busy: fifth kick dropped
    reset_dut(1'b0);
    step(3'b001, 11'h010, 0, 3'b000);
    step(3'b010, 11'h011, 0, 3'b000);
    step(3'b100, 11'h012, 0, 3'b000);
    idle(3);
    chk("full_busy", 32'(busy), 32'b111);
    for (int i = 0; i < 5; i++) step(3'b001, IDX_W'(32'h20 + i), 0, 3'b000);
    idle(1);
    chk("full_count", 32'(fifo_count), 32'd4);
    chk("full_ovf", 32'(ovf_err), 32'd1);

    // Spurious fin, then flush of three queued jobs with H still in flight
    reset_dut(1'b0);
    step(3'b001, 11'h030, 0, 3'b000);
    idle(2);
    step(3'b000, '0, 0, 3'b100);
    idle(1);
    chk("spur_err", 32'(spur_err), 32'd1);
    chk("spur_no_done", 32'(D_done), 32'd0);
    step(3'b001, 11'h031, 0, 3'b000);
    step(3'b010, 11'h032, 0, 3'b000);
    step(3'b100, 11'h033, 0, 3'b000);
    idle(1);
    chk("flush_pre_count", 32'(fifo_count), 32'd3);
    step(3'b010, 11'h034, 1, 3'b000);
    idle(1);
    chk("flush_count", 32'(fifo_count), 32'd0);
    chk("flush_no_ovf", 32'(ovf_err), 32'd0);
    idle(3);
    step(3'b000, '0, 0, 3'b001);
    idle(1);
    chk("flush_H_done", 32'(H_done), 32'd1);
    idle(3);

    // Reset mid-job: everything clears and no done pulses follow
    reset_dut(1'b0);
    step(3'b001, 11'h040, 0, 3'b000);
    step(3'b010, 11'h041, 0, 3'b000);
    step(3'b001, 11'h042, 0, 3'b000);
    step(3'b010, 11'h043, 0, 3'b000);
    idle(1);
    chk("mid_busy", 32'(busy), 32'b011);
    chk("mid_count", 32'(fifo_count), 32'd2);
    reset_dut(1'b1);
    idle(5);

`ifdef ACCEL_TIMEOUT_EN
    // Watchdog: E never returns fin
    reset_dut(1'b0);
    step(3'b010, 11'h077, 0, 3'b000);
    idle(2);
    chk("tmo_E_start", 32'(E_start), 32'd1);
    idle(16);
    chk("tmo_E_done", 32'(E_done), 32'd1);
    chk("tmo_err", 32'(timeout_err), 32'b010);
    chk("tmo_busy", 32'(busy), 32'd0);
    step(3'b000, '0, 0, 3'b010);
    idle(1);
    chk("tmo_late_spur", 32'(spur_err), 32'd1);
`endif

    // Randomized traffic against the model
    reset_dut(1'b0);
    for (int n = 0; n < 4000; n++) begin
      if (n % 1000 == 999) reset_dut(1'b0);
      finp = ((n / 400) % 2 == 0) ? 8 : 40;
      k = 3'b000;
      if ($urandom_range(0, 99) < 35) k = 3'b001 << $urandom_range(0, 2);
      else if ($urandom_range(0, 99) < 8) k = 3'($urandom_range(0, 7));
      for (int e = 0; e < 3; e++) begin
        if (m_busy[e]) f[e] = ($urandom_range(0, 99) < finp);
        else           f[e] = ($urandom_range(0, 199) == 0);
      end
      step(k, IDX_W'($urandom), ($urandom_range(0, 99) < 3), f);
    end
    idle(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
